// File: rtl/pll_lock_rst_seq.sv
// PSRAM reset sequencer: releases rst_out_n after pll_lock is stable and supervises init/lock loss.
// Optional macro PLL_LOCK_RELOCK_CNT_EN adds the saturating relock_count register.
module pll_lock_rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int INIT_TIMEOUT       = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       init_done,
  input  logic       clear_status,
  output logic       rst_out_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int INIT_W = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    WAIT_INIT = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
  logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                   rst_out_n_q, rst_out_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_s;
  logic                   loss_event;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    stab_cnt_d  = '0;
    init_cnt_d  = '0;
    loss_event  = 1'b0;
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_lock};
    lock_s      = sync_q[SYNC_STAGES-1];

    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = STABLE;
      STABLE: begin
        if (!lock_s)                                                state_d = WAIT_LOCK;
        else if (stab_cnt_q == STAB_W'(LOCK_STABLE_CYCLES - 1))     state_d = WAIT_INIT;
        else                                                        stab_cnt_d = stab_cnt_q + 1'b1;
      end
      WAIT_INIT: begin
        // Lock loss outranks both init_done and timeout.
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          loss_event = 1'b1;
        end else if (init_done)                                     state_d = READY;
        else if (init_cnt_q == INIT_W'(INIT_TIMEOUT - 1))           state_d = FAULT;
        else                                                        init_cnt_d = init_cnt_q + 1'b1;
      end
      READY: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      FAULT:   if (!lock_s || clear_status) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase

    lock_lost_d = loss_event | (lock_lost_q & ~clear_status);
    rst_out_n_d = (state_d == WAIT_INIT) || (state_d == READY);
    ready_d     = (state_d == READY);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= WAIT_LOCK;
      sync_q      <= '0;
      stab_cnt_q  <= '0;
      init_cnt_q  <= '0;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      sync_q      <= sync_d;
      stab_cnt_q  <= stab_cnt_d;
      init_cnt_q  <= init_cnt_d;
      rst_out_n_q <= rst_out_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PLL_LOCK_RELOCK_CNT_EN
  logic [7:0] relock_q, relock_d;

  always_comb begin
    relock_d = relock_q;
    if (loss_event && (relock_q != 8'd255)) relock_d = relock_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) relock_q <= 8'd0;
    else         relock_q <= relock_d;
  end

  assign relock_count = relock_q;
`else
  assign relock_count = 8'd0;
`endif

  assign rst_out_n = rst_out_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule
